// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer slice.
//   - DATA_W / NREG / AW : datapath width, register-file depth, address width
//   - alu_op_e           : ALU function codes driven on alu_func
//   - seq_state_e        : sequencer FSM encoding
//   - op_has_carry()     : which ops produce a meaningful carry/borrow
package alu_pkg;

    localparam int DATA_W = 8;
    localparam int NREG   = 4;
    localparam int AW     = 2;

    typedef enum logic [2:0] {
        ALU_ADD    = 3'd0,
        ALU_SUB    = 3'd1,
        ALU_MOVE   = 3'd2,
        ALU_LSHIFT = 3'd3,
        ALU_RSHIFT = 3'd4,
        ALU_AND    = 3'd5,
        ALU_NOT    = 3'd6,
        ALU_OR     = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_EX   = 2'd2,
        ST_WB   = 2'd3
    } seq_state_e;

    // Only the arithmetic ops carry a meaningful Cout; everything else reports 0.
    function automatic logic op_has_carry(input logic [2:0] op);
        case (op)
            ALU_ADD, ALU_SUB: return 1'b1;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction channel between the host and the sequencer.
//   instr_valid : host offers an instruction
//   instr_ready : sequencer can take it (only in IDLE)
//   instr_op    : ALU function code
//   instr_rd    : destination register
//   instr_rs1   : source register feeding alu_in1
//   instr_rs2   : source register feeding alu_in2
// The master modport is the host side. The slave modport is the sequencer side.
interface alu_sequencer_if #(
    parameter int AW = alu_pkg::AW
) ();

    logic          instr_valid;
    logic          instr_ready;
    logic [2:0]    instr_op;
    logic [AW-1:0] instr_rd;
    logic [AW-1:0] instr_rs1;
    logic [AW-1:0] instr_rs2;

    modport master (
        output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
        input  instr_ready
    );

    modport slave (
        input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
        output instr_ready
    );

endinterface

// File: rtl/alu_sequencer_regfile.sv
// regfile_4x8: small register file for the ALU sequencer.
//   clk, rst           : clock and synchronous active-high reset (clears all entries)
//   wr_en/addr/data    : single synchronous write port
//   rd1_addr/rd1_data  : combinational read port (operand 1)
//   rd2_addr/rd2_data  : combinational read port (operand 2)
//   obs_addr/obs_data  : combinational observation port for the host
module regfile_4x8 import alu_pkg::*; #(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int NREG   = alu_pkg::NREG,
    parameter int AW     = alu_pkg::AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd1_addr,
    output logic [DATA_W-1:0] rd1_data,
    input  logic [AW-1:0]     rd2_addr,
    output logic [DATA_W-1:0] rd2_data,
    input  logic [AW-1:0]     obs_addr,
    output logic [DATA_W-1:0] obs_data
);

    logic [DATA_W-1:0] mem_r [NREG];

    // Storage: clear on reset, otherwise accept the single write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd1_data = mem_r[rd1_addr];
    assign rd2_data = mem_r[rd2_addr];
    assign obs_data = mem_r[obs_addr];

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: control side of the 8-bit combinational ALU.
//   clk, rst                 : clock and synchronous active-high reset
//   instr (slave)            : valid/ready instruction channel (op, rd, rs1, rs2)
//   ext_wr_en/addr/data      : host preload of the register file (honoured in IDLE only)
//   obs_addr/obs_data        : combinational view of one register
//   alu_func/alu_in1/alu_in2 : registered drive to the external ALU
//   alu_result/alu_cout      : ALU response, captured in EX
//   done                     : one-cycle pulse during the writeback cycle
//   res/cout/zero            : last written-back result, its carry, and a zero flag
// Each instruction runs IDLE -> RD -> EX -> WB. The register write, and the
// res/cout/zero update, take place on the edge that leaves WB.
module alu_sequencer import alu_pkg::*; #(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int NREG   = alu_pkg::NREG,
    parameter int AW     = alu_pkg::AW
) (
    input  logic              clk,
    input  logic              rst,
    alu_sequencer_if.slave    instr,
    input  logic              ext_wr_en,
    input  logic [AW-1:0]     ext_wr_addr,
    input  logic [DATA_W-1:0] ext_wr_data,
    input  logic [AW-1:0]     obs_addr,
    output logic [DATA_W-1:0] obs_data,
    output logic [2:0]        alu_func,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_cout,
    output logic              done,
    output logic [DATA_W-1:0] res,
    output logic              cout,
    output logic              zero
);

    seq_state_e        state_r;
    seq_state_e        next_state_s;
    logic              accept_s;

    alu_op_e           op_r;
    logic [AW-1:0]     rd_r;
    logic [AW-1:0]     rs1_r;
    logic [AW-1:0]     rs2_r;

    logic [DATA_W-1:0] rs1_data_s;
    logic [DATA_W-1:0] rs2_data_s;

    logic [2:0]        func_r;
    logic [DATA_W-1:0] in1_r;
    logic [DATA_W-1:0] in2_r;

    logic [DATA_W-1:0] result_r;
    logic              carry_r;

    logic [DATA_W-1:0] res_r;
    logic              cout_r;
    logic              zero_r;
    logic              done_r;
    logic              ready_r;

    logic              wr_en_s;
    logic [AW-1:0]     wr_addr_s;
    logic [DATA_W-1:0] wr_data_s;

    // Next-state logic. ready_r is high exactly when state_r is IDLE.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (instr.instr_valid && ready_r) begin
                    accept_s     = 1'b1;
                    next_state_s = ST_RD;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RD:   next_state_s = ST_EX;
            ST_EX:   next_state_s = ST_WB;
            ST_WB:   next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Latch the instruction fields on accept. The host may change them afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r  <= ALU_ADD;
            rd_r  <= {AW{1'b0}};
            rs1_r <= {AW{1'b0}};
            rs2_r <= {AW{1'b0}};
        end else if (accept_s) begin
            op_r  <= alu_op_e'(instr.instr_op);
            rd_r  <= instr.instr_rd;
            rs1_r <= instr.instr_rs1;
            rs2_r <= instr.instr_rs2;
        end
    end

    // Operand fetch in RD. The ALU drive holds its value in all other states.
    always_ff @(posedge clk) begin
        if (rst) begin
            func_r <= 3'd0;
            in1_r  <= {DATA_W{1'b0}};
            in2_r  <= {DATA_W{1'b0}};
        end else if (state_r == ST_RD) begin
            func_r <= op_r;
            in1_r  <= rs1_data_s;
            in2_r  <= rs2_data_s;
        end
    end

    // Capture the ALU response in EX. Cout is masked for the non-arithmetic ops.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_r <= {DATA_W{1'b0}};
            carry_r  <= 1'b0;
        end else if (state_r == ST_EX) begin
            result_r <= alu_result;
            carry_r  <= op_has_carry(op_r) ? alu_cout : 1'b0;
        end
    end

    // Update the visible result and flags on the same edge as the register write.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_r  <= {DATA_W{1'b0}};
            cout_r <= 1'b0;
            zero_r <= 1'b1;
        end else if (state_r == ST_WB) begin
            res_r  <= result_r;
            cout_r <= carry_r;
            zero_r <= (result_r == {DATA_W{1'b0}});
        end
    end

    // Register the handshake outputs from the upcoming state so they stay glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_r <= 1'b1;
            done_r  <= 1'b0;
        end else begin
            ready_r <= (next_state_s == ST_IDLE);
            done_r  <= (next_state_s == ST_WB);
        end
    end

    // Write-port mux: the WB source, else a host preload while IDLE. Host writes
    // in RD/EX/WB are dropped.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = {AW{1'b0}};
        wr_data_s = {DATA_W{1'b0}};
        if (state_r == ST_WB) begin
            wr_en_s   = 1'b1;
            wr_addr_s = rd_r;
            wr_data_s = result_r;
        end else if ((state_r == ST_IDLE) && ext_wr_en) begin
            wr_en_s   = 1'b1;
            wr_addr_s = ext_wr_addr;
            wr_data_s = ext_wr_data;
        end else begin
            wr_en_s   = 1'b0;
        end
    end

    regfile_4x8 #(
        .DATA_W (DATA_W),
        .NREG   (NREG),
        .AW     (AW)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en_s),
        .wr_addr  (wr_addr_s),
        .wr_data  (wr_data_s),
        .rd1_addr (rs1_r),
        .rd1_data (rs1_data_s),
        .rd2_addr (rs2_r),
        .rd2_data (rs2_data_s),
        .obs_addr (obs_addr),
        .obs_data (obs_data)
    );

    assign instr.instr_ready = ready_r;
    assign alu_func          = func_r;
    assign alu_in1           = in1_r;
    assign alu_in2           = in2_r;
    assign done              = done_r;
    assign res               = res_r;
    assign cout              = cout_r;
    assign zero              = zero_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed testbench for alu_sequencer. A behavioural ALU closes the loop.
module tb_alu_sequencer;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ext_wr_en;
    logic [1:0]  ext_wr_addr;
    logic [7:0]  ext_wr_data;
    logic [1:0]  obs_addr;
    logic [7:0]  obs_data;
    logic [2:0]  alu_func;
    logic [7:0]  alu_in1;
    logic [7:0]  alu_in2;
    logic [7:0]  alu_result;
    logic        alu_cout;
    logic        done;
    logic [7:0]  res;
    logic        cout;
    logic        zero;

    int checks = 0;
    int errors = 0;

    alu_sequencer_if #(.AW(2)) instr_bus ();

    alu_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr_bus),
        .ext_wr_en   (ext_wr_en),
        .ext_wr_addr (ext_wr_addr),
        .ext_wr_data (ext_wr_data),
        .obs_addr    (obs_addr),
        .obs_data    (obs_data),
        .alu_func    (alu_func),
        .alu_in1     (alu_in1),
        .alu_in2     (alu_in2),
        .alu_result  (alu_result),
        .alu_cout    (alu_cout),
        .done        (done),
        .res         (res),
        .cout        (cout),
        .zero        (zero)
    );

    always #5 clk = ~clk;

    // Reference ALU. Non-arithmetic ops deliberately drive a nonzero Cout, so
    // the sequencer's masking of Cout is exercised.
    always_comb begin
        alu_result = 8'h00;
        alu_cout   = 1'b0;
        case (alu_func)
            3'd0:    {alu_cout, alu_result} = {1'b0, alu_in1} + {1'b0, alu_in2};
            3'd1:    {alu_cout, alu_result} = {1'b0, alu_in1} - {1'b0, alu_in2};
            3'd2:    begin alu_result = alu_in1;           alu_cout = alu_in1[7]; end
            3'd3:    {alu_cout, alu_result} = {alu_in1, 1'b0};
            3'd4:    begin alu_result = alu_in1 >> 1;      alu_cout = alu_in1[0]; end
            3'd5:    begin alu_result = alu_in1 & alu_in2; alu_cout = alu_in1[7]; end
            3'd6:    begin alu_result = ~alu_in1;          alu_cout = alu_in1[7]; end
            3'd7:    begin alu_result = alu_in1 | alu_in2; alu_cout = alu_in1[7]; end
            default: begin alu_result = 8'h00;             alu_cout = 1'b0;       end
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        checks++;
        assert (got == exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_reg(input string tag, input logic [1:0] addr, input logic [7:0] exp);
        obs_addr = addr;
        #1;
        check8(tag, obs_data, exp);
    endtask

    task automatic preload(input logic [1:0] addr, input logic [7:0] data);
        ext_wr_en   = 1'b1;
        ext_wr_addr = addr;
        ext_wr_data = data;
        tick();
        ext_wr_en   = 1'b0;
    endtask

    // Issue one instruction, then measure the cycles from the accept edge to
    // done. Returns one edge after done, with writeback complete.
    task automatic run_instr(input string tag, input logic [2:0] op, input logic [1:0] rd,
                             input logic [1:0] rs1, input logic [1:0] rs2);
        int lat;
        bit seen;
        check1({tag, "_ready_before"}, instr_bus.instr_ready, 1'b1);
        instr_bus.instr_valid = 1'b1;
        instr_bus.instr_op    = op;
        instr_bus.instr_rd    = rd;
        instr_bus.instr_rs1   = rs1;
        instr_bus.instr_rs2   = rs2;
        tick();
        instr_bus.instr_valid = 1'b0;
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat < 8) begin
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                tick();
                lat++;
            end
        end
        check_int({tag, "_latency"}, lat, 3);
        tick();
        check1({tag, "_done_pulse"}, done, 1'b0);
        check1({tag, "_ready_after"}, instr_bus.instr_ready, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst                   = 1'b1;
        ext_wr_en             = 1'b0;
        ext_wr_addr           = 2'd0;
        ext_wr_data           = 8'h00;
        obs_addr              = 2'd0;
        instr_bus.instr_valid = 1'b0;
        instr_bus.instr_op    = 3'd0;
        instr_bus.instr_rd    = 2'd0;
        instr_bus.instr_rs1   = 2'd0;
        instr_bus.instr_rs2   = 2'd0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check1("rst_ready", instr_bus.instr_ready, 1'b1);
        check1("rst_done", done, 1'b0);
        check8("rst_res", res, 8'h00);
        check1("rst_cout", cout, 1'b0);
        check1("rst_zero", zero, 1'b1);
        check8("rst_func", {5'd0, alu_func}, 8'h00);
        check8("rst_in1", alu_in1, 8'h00);
        check_reg("rst_r3", 2'd3, 8'h00);

        // ADD 5+3 into r2
        preload(2'd0, 8'h05);
        preload(2'd1, 8'h03);
        run_instr("add1", ALU_ADD, 2'd2, 2'd0, 2'd1);
        check8("add1_in1_hold", alu_in1, 8'h05);
        check8("add1_in2_hold", alu_in2, 8'h03);
        check8("add1_res", res, 8'h08);
        check1("add1_cout", cout, 1'b0);
        check1("add1_zero", zero, 1'b0);
        check_reg("add1_r2", 2'd2, 8'h08);

        // ADD wrap-around: FF+01 -> 00, carry out
        preload(2'd0, 8'hFF);
        preload(2'd1, 8'h01);
        run_instr("add2", ALU_ADD, 2'd3, 2'd0, 2'd1);
        check8("add2_res", res, 8'h00);
        check1("add2_cout", cout, 1'b1);
        check1("add2_zero", zero, 1'b1);
        check_reg("add2_r3", 2'd3, 8'h00);

        // AND: the ALU offers Cout=1 here, and it must be masked to 0
        run_instr("and", ALU_AND, 2'd3, 2'd0, 2'd1);
        check8("and_res", res, 8'h01);
        check1("and_cout", cout, 1'b0);
        check1("and_zero", zero, 1'b0);
        check8("and_func_hold", {5'd0, alu_func}, 8'h05);

        // LSHIFT in place: old r1=0x81 is used, and the shifted-out bit is masked
        preload(2'd1, 8'h81);
        run_instr("lsh", ALU_LSHIFT, 2'd1, 2'd1, 2'd1);
        check8("lsh_res", res, 8'h02);
        check1("lsh_cout", cout, 1'b0);
        check_reg("lsh_r1", 2'd1, 8'h02);

        // SUB with borrow: 03-05 = FE, cout=1
        preload(2'd0, 8'h03);
        preload(2'd1, 8'h05);
        run_instr("sub", ALU_SUB, 2'd2, 2'd0, 2'd1);
        check8("sub_res", res, 8'hFE);
        check1("sub_cout", cout, 1'b1);

        // Back-to-back: ADD r2=r0+r1=08, then OR r3=r1|r2=0D, with valid held high
        instr_bus.instr_valid = 1'b1;
        instr_bus.instr_op    = ALU_ADD;
        instr_bus.instr_rd    = 2'd2;
        instr_bus.instr_rs1   = 2'd0;
        instr_bus.instr_rs2   = 2'd1;
        tick();
        instr_bus.instr_op    = ALU_OR;
        instr_bus.instr_rd    = 2'd3;
        instr_bus.instr_rs1   = 2'd1;
        instr_bus.instr_rs2   = 2'd2;
        for (int i = 0; i < 3; i++) begin
            check1("b2b_ready_low", instr_bus.instr_ready, 1'b0);
            tick();
        end
        check1("b2b_ready_back", instr_bus.instr_ready, 1'b1);
        check8("b2b_res1", res, 8'h08);
        tick();
        instr_bus.instr_valid = 1'b0;
        check1("b2b_second_accept", instr_bus.instr_ready, 1'b0);
        tick();
        tick();
        check1("b2b_done2", done, 1'b1);
        tick();
        check8("b2b_res2", res, 8'h0D);
        check_reg("b2b_r3", 2'd3, 8'h0D);

        // Host write during EX is dropped. MOVE r2 <- r1 (05)
        instr_bus.instr_valid = 1'b1;
        instr_bus.instr_op    = ALU_MOVE;
        instr_bus.instr_rd    = 2'd2;
        instr_bus.instr_rs1   = 2'd1;
        instr_bus.instr_rs2   = 2'd0;
        tick();
        instr_bus.instr_valid = 1'b0;
        tick();
        ext_wr_en   = 1'b1;
        ext_wr_addr = 2'd0;
        ext_wr_data = 8'hAA;
        tick();
        ext_wr_en   = 1'b0;
        check1("exwr_done", done, 1'b1);
        tick();
        check_reg("exwr_r0_kept", 2'd0, 8'h03);
        check_reg("exwr_r2", 2'd2, 8'h05);

        // Host write and accept in the same IDLE cycle: RD sees the new r0
        ext_wr_en             = 1'b1;
        ext_wr_addr           = 2'd0;
        ext_wr_data           = 8'hAA;
        instr_bus.instr_valid = 1'b1;
        instr_bus.instr_op    = ALU_MOVE;
        instr_bus.instr_rd    = 2'd1;
        instr_bus.instr_rs1   = 2'd0;
        instr_bus.instr_rs2   = 2'd0;
        tick();
        ext_wr_en             = 1'b0;
        instr_bus.instr_valid = 1'b0;
        tick();
        tick();
        check1("idlewr_done", done, 1'b1);
        tick();
        check_reg("idlewr_r1", 2'd1, 8'hAA);
        check_reg("idlewr_r0", 2'd0, 8'hAA);

        // Reset in EX of SUB aborts the op
        instr_bus.instr_valid = 1'b1;
        instr_bus.instr_op    = ALU_SUB;
        instr_bus.instr_rd    = 2'd2;
        instr_bus.instr_rs1   = 2'd0;
        instr_bus.instr_rs2   = 2'd1;
        tick();
        instr_bus.instr_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check1("abort_ready", instr_bus.instr_ready, 1'b1);
        check1("abort_done", done, 1'b0);
        check8("abort_res", res, 8'h00);
        check1("abort_zero", zero, 1'b1);
        check1("abort_cout", cout, 1'b0);
        check8("abort_in1", alu_in1, 8'h00);
        check_reg("abort_r0", 2'd0, 8'h00);
        check_reg("abort_r1", 2'd1, 8'h00);
        check_reg("abort_r2", 2'd2, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            check1("abort_no_done", done, 1'b0);
        end
        check_reg("abort_r2_late", 2'd2, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
